fft_addr_seq: RTL and testbench



---
 rtl/fft_pkg.sv | 52 +++++
 rtl/addr_delay.sv | 39 +++
 rtl/fft_addr_seq.sv | 196 +++++++++++++++++++
 tb/tb_fft_addr_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT address sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Holds the sequencer state encoding, width derivations and the
// run-time-length bit-reversal helper.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest sample address the bit-reversal helper handles.
  localparam int ADDR_W_MAX = 16;

  // Sample address width: one bit per transform level.
  function automatic int addr_w(input int log2n_max);
    return log2n_max;
  endfunction

  // Twiddle ROM holds half a period, so one bit fewer than samples.
  function automatic int twi_w(input int log2n_max);
    return log2n_max - 1;
  endfunction

  // Stage / size field must be able to hold the value log2n_max itself.
  function automatic int sw_w(input int log2n_max);
    return $clog2(log2n_max + 1);
  endfunction

  // Reverse the low l bits of v; bits at and above l come back as 0.
  // Bits are popped LSB-first and pushed into the result, so after l
  // iterations v[0] sits at position l-1.
  function automatic logic [ADDR_W_MAX-1:0] bitrev(input logic [ADDR_W_MAX-1:0] v,
                                                   input int l);
    logic [ADDR_W_MAX-1:0] r;
    logic [ADDR_W_MAX-1:0] vv;
    r  = '0;
    vv = v;
    for (int i = 0; i < ADDR_W_MAX; i++) begin
      if (i < l) begin
        r  = {r[ADDR_W_MAX-2:0], vv[0]};
        vv = vv >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/addr_delay.sv
// Fixed-depth shift register carrying write-path entries behind their reads.
// Latency: DEPTH cycles (DEPTH=0 is a plain wire).
// Backpressure: none; shifts every cycle, clr empties it synchronously.
//
// Ports: core_clk, arst_n (async active-low), clr (flush), in_dat, out_dat.
module addr_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic [W-1:0] in_dat,
  output logic [W-1:0] out_dat
);

  if (DEPTH == 0) begin : g_wire
    // Clock, reset and flush have nothing to act on at zero depth.
    logic unused_ctl;
    assign unused_ctl = ^{core_clk, arst_n, clr};
    assign out_dat    = in_dat;
  end else begin : g_sr
    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
        sr[0] <= in_dat;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign out_dat = sr[DEPTH-1];
  end

endmodule

// File: rtl/fft_addr_seq.sv
// Walks every stage/butterfly of an in-place radix-2 DIT FFT, issuing read,
//   twiddle and (BFLY_LAT later) write addresses for a run-time size L.
// Latency: first read 1 cycle after accepted start; done at 1 + L*(2^(L-1)+BFLY_LAT).
// Backpressure: none; one pair per cycle, BFLY_LAT drain bubbles between stages.
//
// Ports: i_clk/i_rst_n; i_start/i_log2n request a run; o_busy/o_done/o_err
// report status; o_rd_en + o_even_addr/o_odd_addr/o_twi_addr are the read
// side; o_wr_en + o_top_addr/o_bot_addr the write side; o_stage the stage.
module fft_addr_seq
  import fft_pkg::*;
#(
  parameter int LOG2N_MAX = 8,
  parameter int BFLY_LAT  = 3,
  parameter int SW        = sw_w(LOG2N_MAX)   // derived, leave at default
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SW-1:0]        i_log2n,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_rd_en,
  output logic [LOG2N_MAX-1:0] o_even_addr,
  output logic [LOG2N_MAX-1:0] o_odd_addr,
  output logic [LOG2N_MAX-2:0] o_twi_addr,
  output logic                 o_wr_en,
  output logic [LOG2N_MAX-1:0] o_top_addr,
  output logic [LOG2N_MAX-1:0] o_bot_addr,
  output logic [SW-1:0]        o_stage
);

  localparam int A  = addr_w(LOG2N_MAX);
  localparam int TW = twi_w(LOG2N_MAX);
  localparam int PW = A - 1;                  // pair index: 2^(L-1) pairs max
  localparam int CW = (BFLY_LAT < 2) ? 1 : $clog2(BFLY_LAT + 1);
  localparam int DW = 1 + 2 * A;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d, l_q, l_d;
  logic [PW-1:0]   p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            rd_d, busy_d, done_d, err_d, start_acc, last_p;
  logic [A-1:0]    even_d, odd_d;
  logic [TW-1:0]   twi_d;
  logic [SW-1:0]   stage_d;

  logic [A-1:0]    p_ext, mask, k, g, top_c, bot_c, br_top, br_bot;
  logic [TW-1:0]   twi_c;
  logic [DW-1:0]   dly_in, dly_out;

  // Butterfly geometry for pair p of stage s: group g, offset k within it.
  always_comb begin
    p_ext  = A'(p_q);
    mask   = (A'(1) << s_q) - A'(1);
    k      = p_ext & mask;
    g      = p_ext >> s_q;
    top_c  = ((g << s_q) << 1) | k;
    bot_c  = top_c + (A'(1) << s_q);
    // Twiddle index is scaled to the largest table so it ignores L.
    twi_c  = TW'(k << (SW'(A - 1) - s_q));
    br_top = A'(bitrev(ADDR_W_MAX'(top_c), int'(l_q)));
    br_bot = A'(bitrev(ADDR_W_MAX'(bot_c), int'(l_q)));
    last_p = (p_ext == ((A'(1) << (l_q - SW'(1))) - A'(1)));
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    l_d       = l_q;
    rd_d      = 1'b0;
    even_d    = '0;
    odd_d     = '0;
    twi_d     = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    start_acc = 1'b0;
    stage_d   = o_stage;

    unique case (state_q)
      IDLE: begin
        // o_done still high means this is the done cycle: starts are dropped.
        if (i_start && !o_done) begin
          if (i_log2n >= SW'(1) && i_log2n <= SW'(LOG2N_MAX)) begin
            start_acc = 1'b1;
            l_d       = i_log2n;
            s_d       = '0;
            p_d       = '0;
            state_d   = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        rd_d    = 1'b1;
        even_d  = (s_q == '0) ? br_top : top_c;
        odd_d   = (s_q == '0) ? br_bot : bot_c;
        twi_d   = twi_c;
        stage_d = s_q;
        if (last_p) begin
          p_d = '0;
          if (BFLY_LAT != 0) begin
            state_d = DRAIN;
            cnt_d   = CW'(BFLY_LAT);
          end else if (s_q == l_q - SW'(1)) begin
            state_d = DONE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      DRAIN: begin
        // Hold reads off until the stage's last write has left the pipe.
        stage_d = s_q;
        if (cnt_q == CW'(1)) begin
          if (s_q < l_q - SW'(1)) begin
            s_d     = s_q + SW'(1);
            p_d     = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        stage_d = s_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_q != IDLE) || (state_d != IDLE);
  end

  // Natural-order pair addresses travel with the read and return as writes.
  assign dly_in = {rd_d, rd_d ? top_c : A'(0), rd_d ? bot_c : A'(0)};

  addr_delay #(
    .W     (DW),
    .DEPTH (BFLY_LAT)
  ) u_wr_dly (
    .core_clk (i_clk),
    .arst_n   (i_rst_n),
    .clr      (start_acc),
    .in_dat   (dly_in),
    .out_dat  (dly_out)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      l_q         <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rd_en     <= 1'b0;
      o_even_addr <= '0;
      o_odd_addr  <= '0;
      o_twi_addr  <= '0;
      o_wr_en     <= 1'b0;
      o_top_addr  <= '0;
      o_bot_addr  <= '0;
      o_stage     <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_err       <= err_d;
      o_rd_en     <= rd_d;
      o_even_addr <= even_d;
      o_odd_addr  <= odd_d;
      o_twi_addr  <= twi_d;
      o_wr_en     <= dly_out[DW-1];
      o_top_addr  <= dly_out[2*A-1:A];
      o_bot_addr  <= dly_out[A-1:0];
      o_stage     <= stage_d;
    end
  end

endmodule

// File: tb/tb_fft_addr_seq.sv
// Bench for fft_addr_seq: three instances (LOG2N_MAX/BFLY_LAT = 3/2, 8/3, 3/0).
// Expected per-cycle output records are queued when a run is started and
// popped and compared on every falling clock edge.
module tb_fft_addr_seq;

  typedef struct packed {
    logic       rd;
    logic [7:0] ev;
    logic [7:0] od;
    logic [7:0] tw;
    logic       wr;
    logic [7:0] tp;
    logic [7:0] bt;
    logic [3:0] st;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  localparam int LMX [3] = '{3, 8, 3};
  localparam int LT  [3] = '{2, 3, 0};

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic       start [3];
  logic [3:0] log2n [3];

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  obs_t expq [3][$];
  int   cq   [3][$];
  logic [3:0] last_st [3];
  obs_t ob [3];

  // Instance 0: LOG2N_MAX=3, BFLY_LAT=2
  logic       b0, dn0, er0, rd0, wr0;
  logic [2:0] ev0, od0, tp0, bt0;
  logic [1:0] tw0, st0;
  fft_addr_seq #(.LOG2N_MAX(3), .BFLY_LAT(2)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_start(start[0]), .i_log2n(log2n[0][1:0]),
    .o_busy(b0), .o_done(dn0), .o_err(er0), .o_rd_en(rd0),
    .o_even_addr(ev0), .o_odd_addr(od0), .o_twi_addr(tw0),
    .o_wr_en(wr0), .o_top_addr(tp0), .o_bot_addr(bt0), .o_stage(st0));
  assign ob[0] = {rd0, 8'(ev0), 8'(od0), 8'(tw0), wr0, 8'(tp0), 8'(bt0), 4'(st0), b0, dn0, er0};

  // Instance 1: LOG2N_MAX=8, BFLY_LAT=3
  logic       b1, dn1, er1, rd1, wr1;
  logic [7:0] ev1, od1, tp1, bt1;
  logic [6:0] tw1;
  logic [3:0] st1;
  fft_addr_seq #(.LOG2N_MAX(8), .BFLY_LAT(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_start(start[1]), .i_log2n(log2n[1]),
    .o_busy(b1), .o_done(dn1), .o_err(er1), .o_rd_en(rd1),
    .o_even_addr(ev1), .o_odd_addr(od1), .o_twi_addr(tw1),
    .o_wr_en(wr1), .o_top_addr(tp1), .o_bot_addr(bt1), .o_stage(st1));
  assign ob[1] = {rd1, ev1, od1, 8'(tw1), wr1, tp1, bt1, st1, b1, dn1, er1};

  // Instance 2: LOG2N_MAX=3, BFLY_LAT=0
  logic       b2, dn2, er2, rd2, wr2;
  logic [2:0] ev2, od2, tp2, bt2;
  logic [1:0] tw2, st2;
  fft_addr_seq #(.LOG2N_MAX(3), .BFLY_LAT(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_start(start[2]), .i_log2n(log2n[2][1:0]),
    .o_busy(b2), .o_done(dn2), .o_err(er2), .o_rd_en(rd2),
    .o_even_addr(ev2), .o_odd_addr(od2), .o_twi_addr(tw2),
    .o_wr_en(wr2), .o_top_addr(tp2), .o_bot_addr(bt2), .o_stage(st2));
  assign ob[2] = {rd2, 8'(ev2), 8'(od2), 8'(tw2), wr2, 8'(tp2), 8'(bt2), 4'(st2), b2, dn2, er2};

  // Reference geometry straight from the butterfly definition.
  function automatic int top_of(input int s, input int p);
    return ((p >> s) << (s + 1)) | (p & ((1 << s) - 1));
  endfunction

  function automatic int br(input int v, input int l);
    int r;
    r = 0;
    for (int i = 0; i < l; i++) r |= ((v >> i) & 1) << (l - 1 - i);
    return r;
  endfunction

  // Addresses only carry meaning while their enable is high.
  function automatic obs_t msk(input obs_t o);
    obs_t r;
    r = o;
    if (!r.rd) begin r.ev = '0; r.od = '0; r.tw = '0; end
    if (!r.wr) begin r.tp = '0; r.bt = '0; end
    return r;
  endfunction

  // Queue the expected outputs for cycles 0..T+extra of a run of size L.
  task automatic gen(input int id, input int L, input int extra);
    int lat, lmx, np, per, tt;
    lat = LT[id];
    lmx = LMX[id];
    np  = 1 << (L - 1);
    per = np + lat;
    tt  = 1 + L * per;
    for (int c = 0; c <= tt + extra; c++) begin
      obs_t e;
      int sv, s, p, t;
      e      = '0;
      e.busy = (c <= tt);
      e.done = (c == tt);
      if (c == 0) e.st = last_st[id];
      else begin
        sv = (c - 1) / per;
        if (sv > L - 1) sv = L - 1;
        e.st = 4'(sv);
      end
      if (c >= 1) begin
        s = (c - 1) / per;
        p = (c - 1) % per;
        if (s < L && p < np) begin
          t    = top_of(s, p);
          e.rd = 1'b1;
          e.ev = 8'((s == 0) ? br(t, L) : t);
          e.od = 8'((s == 0) ? br(t + (1 << s), L) : t + (1 << s));
          e.tw = 8'((p & ((1 << s) - 1)) << (lmx - 1 - s));
        end
      end
      if (c - lat >= 1) begin
        s = (c - lat - 1) / per;
        p = (c - lat - 1) % per;
        if (s < L && p < np) begin
          t    = top_of(s, p);
          e.wr = 1'b1;
          e.tp = 8'(t);
          e.bt = 8'(t + (1 << s));
        end
      end
      expq[id].push_back(e);
      cq[id].push_back(c);
    end
    last_st[id] = 4'(L - 1);
  endtask

  // Start a run; optionally pulse start mid-run and on the done cycle.
  task automatic run(input int id, input int L, input int extra,
                     input bit start_at_done, input bit start_midrun);
    int tt;
    tt = 1 + L * ((1 << (L - 1)) + LT[id]);
    @(posedge clk); #1 start[id] = 1'b1; log2n[id] = 4'(L);
    @(posedge clk); #1 start[id] = 1'b0;
    gen(id, L, extra);
    if (start_midrun) begin
      repeat (3) @(posedge clk);
      #1 start[id] = 1'b1; log2n[id] = 4'd2;
      repeat (4) @(posedge clk);
      #1 start[id] = 1'b0;
      repeat (tt - 7) @(posedge clk);
    end else begin
      repeat (tt) @(posedge clk);
    end
    if (start_at_done) begin
      #1 start[id] = 1'b1; log2n[id] = 4'(L);
      @(posedge clk);
      #1 start[id] = 1'b0;
    end
    repeat (extra + 2) @(posedge clk);
  endtask

  // Rejected size: o_err pulse, busy stays low, stage unchanged.
  task automatic bad_start(input int id, input int L);
    obs_t e;
    @(posedge clk); #1 start[id] = 1'b1; log2n[id] = 4'(L);
    @(posedge clk); #1 start[id] = 1'b0;
    e = '0; e.st = last_st[id]; e.err = 1'b1;
    expq[id].push_back(e); cq[id].push_back(0);
    e.err = 1'b0;
    expq[id].push_back(e); cq[id].push_back(1);
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (expq[i].size() != 0) begin
        obs_t e, o;
        int c;
        e = expq[i].pop_front();
        c = cq[i].pop_front();
        o = msk(ob[i]);
        n_chk++;
        assert (o === e) else begin
          n_err++;
          $error("FAIL seq dut%0d cycle %0d: observed %h, expected %h", i, c, o, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; log2n[i] = '0; last_st[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      assert (ob[i] === obs_t'(0)) else begin
        n_err++;
        $error("FAIL reset dut%0d: observed %h, expected 0", i, ob[i]);
      end
      rst_n[i] = 1'b1;
    end

    // LOG2N_MAX=3, LAT=2: full L=3 walk, start on the done cycle ignored.
    run(0, 3, 2, 1'b1, 1'b0);
    run(0, 1, 1, 1'b0, 1'b0);
    run(0, 2, 1, 1'b0, 1'b0);

    // LOG2N_MAX=8, LAT=3: L=4 with starts while busy, bad sizes, full L=8.
    run(1, 4, 1, 1'b0, 1'b1);
    bad_start(1, 0);
    bad_start(1, 9);
    run(1, 8, 1, 1'b0, 1'b0);

    // Reset in the middle of the first drain of an L=3 run.
    @(posedge clk); #1 start[0] = 1'b1; log2n[0] = 4'd3;
    @(posedge clk); #1 start[0] = 1'b0;
    gen(0, 3, 0);
    repeat (5) @(posedge clk);
    #1;
    expq[0].delete();
    cq[0].delete();
    rst_n[0] = 1'b0;
    #1;
    n_chk++;
    assert (ob[0] === obs_t'(0)) else begin
      n_err++;
      $error("FAIL async_rst dut0: observed %h, expected 0", ob[0]);
    end
    last_st[0] = '0;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    run(0, 3, 1, 1'b0, 1'b0);

    // LAT=0: writes coincide with reads, no bubbles.
    run(2, 2, 1, 1'b0, 1'b0);
    run(2, 3, 1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
